// File: rtl/router_pkg.sv
// Shared types and defaults for the reset controller.
// States, default parameters.
package router_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_RUN,
        ST_SOFT,
        ST_ACK
    } rst_state_t;

    localparam int RST_SYNC_STAGES_DEF = 2;
    localparam int RST_HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/clk_rst.sv
// Clock/reset bundle handed to downstream logic.
// The source side drives everything.
interface clk_rst;

    logic clk;
    logic arst;
    logic arst_n;
    logic srst;
    logic srst_n;

    modport source (
        output clk,
        output arst,
        output arst_n,
        output srst,
        output srst_n
    );

    modport sink (
        input clk,
        input arst,
        input arst_n,
        input srst,
        input srst_n
    );

endinterface

// File: rtl/rst_sync.sv
// Async-set reset synchroniser chain.
// Output stays high while any stage is still set.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    output logic sync_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], 1'b0};
        end
    end

    assign sync_o = |ff_q;

endmodule

// File: rtl/rst_ctrl.sv
// Reset sequencer: power-on hold, soft-reset handshake,
// and the core reset bundle (async and sync flavours).
module rst_ctrl
    import router_pkg::*;
#(
    parameter int SYNC_STAGES = RST_SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic CLK,
    input  logic ARST,
    input  logic SW_RST_REQ,
    output logic SW_RST_ACK,
    output logic CORE_ARST,
    output logic CORE_ARSTn,
    output logic CORE_SRST,
    output logic CORE_SRSTn,
    output logic RST_DONE
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    clk_rst u_cr ();

    logic       sync_rst;
    rst_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       arst_q, arst_d;
    logic       srst_q, srst_d;
    logic       ack_q, ack_d;
    logic       done_q, done_d;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (u_cr.clk),
        .arst_i (ARST),
        .sync_o (sync_rst)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_RESET: begin
                if (!sync_rst) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == LAST) state_d = ST_RUN;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (SW_RST_REQ) state_d = ST_SOFT;
            end
            ST_SOFT: begin
                if (cnt_q == LAST) state_d = ST_ACK;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_ACK: begin
                if (!SW_RST_REQ) state_d = ST_RUN;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Outputs are registered decodes of the next state.
    always_comb begin
        arst_d = (state_d == ST_RESET) || (state_d == ST_HOLD);
        srst_d = arst_d || (state_d == ST_SOFT);
        ack_d  = (state_d == ST_ACK);
        done_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            arst_q  <= 1'b1;
            srst_q  <= 1'b1;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arst_q  <= arst_d;
            srst_q  <= srst_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign u_cr.clk    = CLK;
    assign u_cr.arst   = arst_q;
    assign u_cr.arst_n = ~arst_q;
    assign u_cr.srst   = srst_q;
    assign u_cr.srst_n = ~srst_q;

    assign CORE_ARST  = u_cr.arst;
    assign CORE_ARSTn = u_cr.arst_n;
    assign CORE_SRST  = u_cr.srst;
    assign CORE_SRSTn = u_cr.srst_n;
    assign SW_RST_ACK = ack_q;
    assign RST_DONE   = done_q;

endmodule

// File: doc/rst_ctrl.md
RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of reset-synchroniser flops; legal range >= 2.
REQ-002 Parameter HOLD_CYCLES, default 16, cycles the resets stay asserted after synchroniser release; legal range >= 1.
REQ-003 CLK  input  1  single clock; all flops rising-edge.
REQ-004 ARST  input  1  asynchronous, active-high reset.
REQ-005 SW_RST_REQ  input  1  soft-reset request, synchronous to CLK, level, 4-phase.
REQ-006 SW_RST_ACK  output  1  soft-reset complete; held until SW_RST_REQ drops.
REQ-007 CORE_ARST  output  1  async-assert/sync-deassert active-high reset for the clk_rst bundle.
REQ-008 CORE_ARSTn  output  1  exact complement of CORE_ARST.
REQ-009 CORE_SRST  output  1  fully synchronous active-high reset for the clk_rst bundle.
REQ-010 CORE_SRSTn  output  1  exact complement of CORE_SRST.
REQ-011 RST_DONE  output  1  high only in state RUN.

Function
REQ-012 Synchroniser: SYNC_STAGES flops, all async-set by ARST, shifting in 0 each edge; output high while any stage is high.
REQ-013 FSM states: RESET, HOLD, RUN, SOFT, ACK; all outputs are registered decodes of the next state.
REQ-014 RESET -> HOLD on the first edge where synchroniser output is low; hold counter loads 0.
REQ-015 HOLD: counter increments each edge; on the edge where counter == HOLD_CYCLES-1, -> RUN.
REQ-016 Latency: CORE_ARST/CORE_SRST fall on edge SYNC_STAGES+1+HOLD_CYCLES counting from the first rising edge after ARST falls (19 with defaults).
REQ-017 RUN -> SOFT on any edge sampling SW_RST_REQ=1; counter loads 0.
REQ-018 SOFT: CORE_SRST=1, CORE_ARST=0; counter as in HOLD; on counter == HOLD_CYCLES-1, -> ACK.
REQ-019 ACK: CORE_SRST=0, SW_RST_ACK=1, RST_DONE=0; -> RUN on first edge sampling SW_RST_REQ=0.
REQ-020 Output table: RESET/HOLD: ARST=1, SRST=1; RUN: both 0; SOFT: ARST=0, SRST=1; ACK: both 0.
REQ-021 SW_RST_REQ in RESET/HOLD is ignored; if still high on the RUN-entry edge, RUN -> SOFT on the next edge (single RUN cycle with RST_DONE=1).
REQ-022 SW_RST_REQ dropping during SOFT does not shorten SOFT; ACK then lasts exactly one cycle.
REQ-023 Counter width $clog2(HOLD_CYCLES+1); counter never wraps; held at 0 outside HOLD/SOFT.
REQ-024 ARST glitch shorter than one cycle still restarts the full sequence from RESET.

Reset
REQ-025 ARST asserts CORE_ARST=1, CORE_ARSTn=0 asynchronously, with no clock required.
REQ-026 ARST asynchronously forces state RESET, counter 0, synchroniser all 1, CORE_SRST=1, CORE_SRSTn=0, SW_RST_ACK=0, RST_DONE=0.
REQ-027 ARST in any state, including SOFT and ACK, aborts the operation; no ACK is issued for the aborted request.
REQ-028 No deassertion of any output occurs asynchronously; all releases occur on CLK rising edges.

Structure
REQ-029 router_pkg holds rst_state_t (enum of the five states) plus RST_SYNC_STAGES_DEF=2 and RST_HOLD_CYCLES_DEF=16.
REQ-030 One sub-module, rst_sync: a parameterised async-set synchroniser chain instantiated once.
REQ-031 The top-level connects CORE_* outputs and CLK to a clk_rst instance through its source modport.

Verification
REQ-032 ARST pulse of 3 cycles, then low, defaults: CORE_ARST/SRST fall at edge 19 after release; RST_DONE rises on the same edge; complements track.
REQ-033 ARST asserted between edges in RUN: CORE_ARST=1 and RST_DONE=0 before the next edge; full 19-edge release follows.
REQ-034 In RUN, SW_RST_REQ=1 held: CORE_SRST=1 for 16 cycles, CORE_ARST stays 0, then ACK=1; REQ=0 drops ACK and enters RUN next edge.
REQ-035 SW_RST_REQ held high through power-on: exactly one RUN cycle, then SOFT; ACK only after the 16-cycle hold.
REQ-036 ARST at SOFT cycle 8: immediate RESET, SW_RST_ACK never asserts, full sequence restarts.
REQ-037 SYNC_STAGES=3, HOLD_CYCLES=1: release at edge 5; 1-cycle REQ pulse gives SOFT 1 cycle and ACK 1 cycle.
